burst_mem_responder: RTL

Synthesizable responder for the 64-bit, 4-beat burst memory port driven by the `mp4` cache hierarchy (`mem_read`/`mem_write`/`mem_addr`/`mem_wdata`/`mem_rdata`/`mem_resp`). It serves whole 256-bit cache-line reads and writes from an on-chip backing store with a fixed, parameterized access latency. It replaces the behavioural burst memory for FPGA/standalone runs and serves as the reference responder for cache-side verification.

---
 rtl/burst_mem_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/burst_mem_responder.sv
// Line-granular responder for a 64-bit, 4-beat burst memory port.
// Serves 256-bit line reads and writes from an on-chip store after a fixed latency.
module burst_mem_responder #(
    parameter int LINE_BITS = 10,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [63:0] mem_wdata,
    output logic [63:0] mem_rdata,
    output logic        mem_resp,
    output logic        busy,
    output logic        proto_err,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is accepted when mem_read|mem_write is sampled high in
    // IDLE; the initiator holds it through the 4 mem_resp beats, then may drop it.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int WORDS = 1 << (LINE_BITS + 2);
    localparam logic [3:0] WAIT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [63:0]          mem_q [WORDS];
    state_t               state_q;
    logic [3:0]           lat_q;
    logic [1:0]           beat_q;
    logic [LINE_BITS-1:0] idx_q;
    logic                 op_wr_q;
    logic [63:0]          rdata_q;
    logic                 resp_q;
    logic                 busy_q;
    logic                 perr_q;

    logic [LINE_BITS-1:0] req_idx_d;
    logic                 req_held_d;
    logic                 unused_addr_bits;

    assign req_idx_d        = mem_addr[LINE_BITS+4:5];
    assign req_held_d       = op_wr_q ? mem_write : mem_read;
    assign unused_addr_bits = ^{mem_addr[31:LINE_BITS+5], mem_addr[4:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lat_q   <= 4'd0;
            beat_q  <= 2'd0;
            idx_q   <= '0;
            op_wr_q <= 1'b0;
            rdata_q <= 64'd0;
            resp_q  <= 1'b0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_read || mem_write) begin
                        idx_q   <= req_idx_d;
                        op_wr_q <= mem_write && !mem_read;
                        busy_q  <= 1'b1;
                        lat_q   <= 4'd0;
                        beat_q  <= 2'd0;
                        if (mem_read && mem_write) begin
                            perr_q <= 1'b1;
                        end
                        // With a 1-cycle latency the beat-0 fetch happens right here.
                        if (LATENCY == 1) begin
                            state_q <= S_BURST;
                            resp_q  <= 1'b1;
                            rdata_q <= mem_read ? mem_q[{req_idx_d, 2'b00}] : 64'd0;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req_held_d) begin
                        perr_q <= 1'b1;
                    end
                    if (lat_q == WAIT_LAST) begin
                        state_q <= S_BURST;
                        resp_q  <= 1'b1;
                        rdata_q <= op_wr_q ? 64'd0 : mem_q[{idx_q, 2'b00}];
                    end else begin
                        lat_q <= lat_q + 4'd1;
                    end
                end
                S_BURST: begin
                    if (!req_held_d) begin
                        perr_q <= 1'b1;
                    end
                    if (beat_q == 2'd3) begin
                        state_q <= S_DONE;
                        resp_q  <= 1'b0;
                        rdata_q <= 64'd0;
                    end else begin
                        beat_q  <= beat_q + 2'd1;
                        rdata_q <= op_wr_q ? 64'd0 : mem_q[{idx_q, beat_q + 2'd1}];
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    lat_q   <= 4'd0;
                    beat_q  <= 2'd0;
                end
            endcase
        end
    end

    // Store is not reset; an async reset leaves state_q in IDLE so no further beats commit.
    always_ff @(posedge clk) begin
        if (state_q == S_BURST && op_wr_q) begin
            mem_q[{idx_q, beat_q}] <= mem_wdata;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_resp  = resp_q;
    assign busy      = busy_q;
    assign proto_err = perr_q;
    assign dbg_state = state_q;

endmodule
